// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit data-memory port split into two 16-bit async SRAM half-accesses
// While an access is in flight ready stays low; the pipeline uses ~ready as its global freeze.
module sram_controller #(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int               CNT_W    = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_wr_q, op_wr_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0] offset;
  logic [16:0] idx;
  logic        req;
  logic        last;
  logic        hi_phase;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        unused_offset_bits;

  assign req      = wr_en | rd_en;
  assign offset   = address - BASE_ADDR;
  // Word index wraps modulo 2^17; bits outside it are deliberately ignored.
  assign idx      = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign last     = (cnt_q == CNT_LAST);
  assign hi_phase = (state_q == S_HIGH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = '0;
          op_wr_d = wr_en;
        end
      end
      S_LOW: begin
        if (last) begin
          if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (last) begin
          if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // The request still asserted here belongs to the completing instruction.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    if (state_q == S_LOW || state_q == S_HIGH) begin
      SRAM_ADDR = {idx, hi_phase};
      dq_out    = hi_phase ? writeData[31:16] : writeData[15:0];
      if (op_wr_q) begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign readData  = rdata_q;
  assign ready     = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller
// Expected per-cycle pin states are queued with each request and consumed by a negedge monitor.
module tb_sram_controller;

  localparam logic [15:0] KEEP = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst, rst1, wr_en, rd_en;
  logic [31:0] address, writeData;

  wire  [15:0] dq0, dq1;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic [17:0] addr0, addr1;
  logic        we0, oe0, ce0, ub0, lb0;
  logic        we1, oe1, ce1, ub1, lb1;

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  sram_controller #(.PHASE_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(writeData), .readData(rdata0), .ready(ready0), .SRAM_DQ(dq0),
    .SRAM_ADDR(addr0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );

  sram_controller #(.PHASE_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(writeData), .readData(rdata1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(addr1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  // SRAM model: drives stored data on reads and a keeper pattern whenever the bus would float.
  assign dq0 = we0 ? (oe0 ? KEEP : mem[addr0[9:0]]) : 16'bz;
  assign dq1 = we1 ? KEEP : 16'bz;

  always @(posedge clk) begin
    if (!we0) mem[addr0[9:0]] <= dq0;
  end

  typedef struct packed {
    logic        rdy;
    logic [17:0] addr;
    logic        we_n;
    logic        oe_n;
    logic [15:0] dq;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        mon_sel = 1'b0;
  logic [31:0] cur_rd = '0;

  logic        s_rdy, s_we, s_oe;
  logic [17:0] s_addr;
  logic [15:0] s_dq;
  logic [31:0] s_rd;

  assign s_rdy  = mon_sel ? ready1 : ready0;
  assign s_we   = mon_sel ? we1    : we0;
  assign s_oe   = mon_sel ? oe1    : oe0;
  assign s_addr = mon_sel ? addr1  : addr0;
  assign s_dq   = mon_sel ? dq1    : dq0;
  assign s_rd   = mon_sel ? rdata1 : rdata0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (s_rdy !== mon_e.rdy) begin
        errors++;
        $display("FAIL sb_ready t=%0t got %0b exp %0b", $time, s_rdy, mon_e.rdy);
      end
      checks++;
      if (s_addr !== mon_e.addr) begin
        errors++;
        $display("FAIL sb_addr t=%0t got %0h exp %0h", $time, s_addr, mon_e.addr);
      end
      checks++;
      if (s_we !== mon_e.we_n || s_oe !== mon_e.oe_n) begin
        errors++;
        $display("FAIL sb_we_oe t=%0t got %0b%0b exp %0b%0b", $time, s_we, s_oe, mon_e.we_n, mon_e.oe_n);
      end
      checks++;
      if (s_dq !== mon_e.dq) begin
        errors++;
        $display("FAIL sb_dq t=%0t got %0h exp %0h", $time, s_dq, mon_e.dq);
      end
      if (mon_e.chk_rd) begin
        checks++;
        if (s_rd !== mon_e.rd) begin
          errors++;
          $display("FAIL sb_readData t=%0t got %0h exp %0h", $time, s_rd, mon_e.rd);
        end
      end
    end
  end

  // Queue IDLE-with-request, PHASE cycles per half, then DONE; then hold the request through DONE.
  task automatic do_access(input int pc, input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [16:0] idx, input logic [31:0] rd_after);
    exp_t e;
    logic [15:0] half;
    wr_en     = wr;
    rd_en     = rd;
    address   = addr;
    writeData = wd;
    e = '{rdy: 1'b0, addr: 18'd0, we_n: 1'b1, oe_n: 1'b1, dq: KEEP, chk_rd: 1'b1, rd: cur_rd};
    exp_q.push_back(e);
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c < pc; c++) begin
        if (wr) half = (h == 1) ? wd[31:16] : wd[15:0];
        else    half = (h == 1) ? rd_after[31:16] : rd_after[15:0];
        e = '{rdy: 1'b0, addr: {idx, (h == 1)}, we_n: !wr, oe_n: wr, dq: half, chk_rd: 1'b0, rd: 32'd0};
        exp_q.push_back(e);
      end
    end
    e = '{rdy: 1'b1, addr: 18'd0, we_n: 1'b1, oe_n: 1'b1, dq: KEEP, chk_rd: 1'b1, rd: rd_after};
    exp_q.push_back(e);
    repeat (2 * pc + 2) @(negedge clk);
    @(posedge clk);
    #1;
    cur_rd = rd_after;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ready0 !== 1'b1 || we0 !== 1'b1 || oe0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/we/oe %0b%0b%0b exp 111", ready0, we0, oe0);
    end
    checks++;
    if (addr0 !== 18'd0 || rdata0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got addr %0h rd %0h exp 0 0", addr0, rdata0);
    end
    checks++;
    if (dq0 !== KEEP) begin
      errors++;
      $display("FAIL reset_dq got %0h exp %0h", dq0, KEEP);
    end
    checks++;
    if ({ce0, ub0, lb0} !== 3'b000) begin
      errors++;
      $display("FAIL tie_offs got %0b exp 000", {ce0, ub0, lb0});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1 || we0 !== 1'b1 || oe0 !== 1'b1 || addr0 !== 18'd0) begin
        errors++;
        $display("FAIL idle cyc %0d got rdy %0b we %0b oe %0b addr %0h exp 1 1 1 0", i, ready0, we0, oe0, addr0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    do_access(2, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 17'd1, cur_rd);
    wr_en = 1'b0;
  endtask

  task automatic test_read();
    do_access(2, 1'b0, 1'b1, 32'd1028, 32'h0, 17'd1, 32'hDEADBEEF);
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_access(2, 1'b1, 1'b0, 32'd1024, 32'h12345678, 17'd0, cur_rd);
    do_access(2, 1'b0, 1'b1, 32'd1024, 32'h0, 17'd0, 32'h12345678);
    rd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1 || oe0 !== 1'b1 || rdata0 !== 32'h12345678) begin
        errors++;
        $display("FAIL b2b_after cyc %0d got rdy %0b oe %0b rd %0h exp 1 1 12345678", i, ready0, oe0, rdata0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    do_access(2, 1'b1, 1'b0, 32'd1024 + 32'd524288, 32'hABCD0123, 17'd0, cur_rd);
    do_access(2, 1'b0, 1'b1, 32'd1024, 32'h0, 17'd0, 32'hABCD0123);
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    wr_en     = 1'b1;
    address   = 32'd1028;
    writeData = 32'h55AA33CC;
    repeat (2) @(negedge clk);
    checks++;
    if (we0 !== 1'b0 || dq0 !== 16'h33CC) begin
      errors++;
      $display("FAIL midrst_pre got we %0b dq %0h exp 0 33cc", we0, dq0);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (we0 !== 1'b1 || oe0 !== 1'b1 || addr0 !== 18'd0 || dq0 !== KEEP) begin
      errors++;
      $display("FAIL midrst_pins got we %0b oe %0b addr %0h dq %0h exp 1 1 0 %0h", we0, oe0, addr0, dq0, KEEP);
    end
    checks++;
    if (rdata0 !== 32'd0 || ready0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regs got rd %0h rdy %0b exp 0 0", rdata0, ready0);
    end
    wr_en = 1'b0;
    #1;
    rst = 1'b1;
    cur_rd = 32'd0;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1 || we0 !== 1'b1 || addr0 !== 18'd0) begin
      errors++;
      $display("FAIL midrst_idle got rdy %0b we %0b addr %0h exp 1 1 0", ready0, we0, addr0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_phase1_both();
    rst     = 1'b0;
    rst1    = 1'b1;
    mon_sel = 1'b1;
    cur_rd  = 32'd0;
    do_access(1, 1'b1, 1'b1, 32'd1032, 32'h0F0FF0F0, 17'd2, 32'd0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || we1 !== 1'b1) begin
      errors++;
      $display("FAIL p1_after got rdy %0b we %0b exp 1 1", ready1, we1);
    end
    mon_sel = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    rst1      = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    address   = '0;
    writeData = '0;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_back_to_back();
    test_wrap();
    test_reset_mid_access();
    test_phase1_both();
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
